// File: rtl/cpu_pkg.sv
// Shared types, opcodes and decode helpers for the multi-cycle CPU core.
package cpu_pkg;

  typedef enum logic [2:0] {
    CPU_RESET,
    CPU_FETCH,
    CPU_DECODE,
    CPU_EXECUTE,
    CPU_MEM,
    CPU_WRITEBACK,
    CPU_HALT,
    CPU_FAULT
  } cpu_state_t;

  typedef enum logic [1:0] {
    FLT_NONE,
    FLT_ILLEGAL,
    FLT_MISALIGN,
    FLT_TIMEOUT
  } cpu_fault_t;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_AND  = 6'h02;
  localparam logic [5:0] OP_OR   = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_HALT = 6'h3F;

  function automatic logic op_is_legal(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_BEQ,
      OP_ADDI, OP_LW, OP_SW, OP_HALT: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_mc_core_if.sv
// Memory request/acknowledge port between the CPU core and the SoC memory.
interface cpu_mc_core_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_we;
  logic                  mem_req;
  logic                  mem_ack;

  modport master (
    output mem_addr, mem_wdata, mem_we, mem_req,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, mem_req,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/cpu_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port, r0 reads as zero.
module cpu_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic [$clog2(NUM_REGS)-1:0] raddr_a,
  output logic [DATA_WIDTH-1:0]       rdata_a,
  input  logic [$clog2(NUM_REGS)-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0]       rdata_b
);
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];
endmodule

// File: rtl/cpu_mc_core.sv
// Multi-cycle CPU core: fetch/decode/execute/mem/writeback FSM with fault reporting,
// memory request timeout and retired-instruction counter.
module cpu_mc_core
  import cpu_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    NUM_REGS   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_mc_core_if.master        mem,
  output cpu_state_t           state,
  output logic                 halted,
  output logic                 fault,
  output cpu_fault_t           fault_code,
  output logic [31:0]          instret
);
  localparam int IDX_W = $clog2(NUM_REGS);

  cpu_state_t            state_next;
  cpu_fault_t            fault_next;
  logic [31:0]           ir;
  logic [ADDR_WIDTH-1:0] pc, next_pc, ea, ea_calc, pc_plus4, branch_target;
  logic [DATA_WIDTH-1:0] result, store_data;
  logic [DATA_WIDTH-1:0] rs_val, rt_val, sext_imm, sum_imm, alu_out;
  logic [31:0]           wait_cnt;
  logic                  xfer_done, timed_out, rf_we;
  logic [IDX_W-1:0]      rf_waddr;

  logic [5:0]       op;
  logic [IDX_W-1:0] rs_idx, rt_idx, rd_idx;
  logic [15:0]      imm;

  assign op     = ir[31:26];
  assign rs_idx = ir[21 +: IDX_W];
  assign rt_idx = ir[16 +: IDX_W];
  assign rd_idx = ir[11 +: IDX_W];
  assign imm    = ir[15:0];

  cpu_regfile #(.DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (result),
    .raddr_a (rs_idx),
    .rdata_a (rs_val),
    .raddr_b (rt_idx),
    .rdata_b (rt_val)
  );

  assign sext_imm      = {{(DATA_WIDTH-16){imm[15]}}, imm};
  assign sum_imm       = rs_val + sext_imm;
  assign ea_calc       = ADDR_WIDTH'(sum_imm);
  assign pc_plus4      = pc + ADDR_WIDTH'(4);
  assign branch_target = pc_plus4 + {{(ADDR_WIDTH-18){imm[15]}}, imm, 2'b00};

  always_comb begin
    alu_out = sum_imm;
    case (op)
      OP_ADD:  alu_out = rs_val + rt_val;
      OP_SUB:  alu_out = rs_val - rt_val;
      OP_AND:  alu_out = rs_val & rt_val;
      OP_OR:   alu_out = rs_val | rt_val;
      default: alu_out = sum_imm;
    endcase
  end

  assign mem.mem_req   = (state == CPU_FETCH) || (state == CPU_MEM);
  assign mem.mem_we    = (state == CPU_MEM) && (op == OP_SW);
  assign mem.mem_addr  = (state == CPU_FETCH) ? pc : ((state == CPU_MEM) ? ea : '0);
  assign mem.mem_wdata = mem.mem_we ? store_data : '0;

  assign xfer_done = mem.mem_req & mem.mem_ack;
  // A completing ack takes priority over an expiring wait count.
  assign timed_out = (TIMEOUT != 0) && !xfer_done && (wait_cnt == 32'(TIMEOUT - 1));

  assign rf_we    = (state == CPU_WRITEBACK) &&
                    (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LW});
  assign rf_waddr = (op == OP_ADDI || op == OP_LW) ? rt_idx : rd_idx;

  always_ff @(posedge clk) begin
    if (rst) state <= CPU_RESET;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    fault_next = FLT_NONE;
    case (state)
      CPU_RESET:     state_next = CPU_FETCH;
      CPU_FETCH: begin
        if (xfer_done)      state_next = CPU_DECODE;
        else if (timed_out) begin
          state_next = CPU_FAULT;
          fault_next = FLT_TIMEOUT;
        end
      end
      CPU_DECODE: begin
        if (op_is_legal(op)) state_next = CPU_EXECUTE;
        else begin
          state_next = CPU_FAULT;
          fault_next = FLT_ILLEGAL;
        end
      end
      CPU_EXECUTE: begin
        if (op == OP_HALT) state_next = CPU_HALT;
        else if (op == OP_LW || op == OP_SW) begin
          if (ea_calc[1:0] != 2'b00) begin
            state_next = CPU_FAULT;
            fault_next = FLT_MISALIGN;
          end else begin
            state_next = CPU_MEM;
          end
        end else state_next = CPU_WRITEBACK;
      end
      CPU_MEM: begin
        if (xfer_done)      state_next = CPU_WRITEBACK;
        else if (timed_out) begin
          state_next = CPU_FAULT;
          fault_next = FLT_TIMEOUT;
        end
      end
      CPU_WRITEBACK: state_next = CPU_FETCH;
      default:       state_next = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      ir         <= '0;
      ea         <= '0;
      next_pc    <= '0;
      result     <= '0;
      store_data <= '0;
      wait_cnt   <= '0;
      halted     <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FLT_NONE;
      instret    <= '0;
    end else begin
      wait_cnt <= (mem.mem_req && !mem.mem_ack) ? wait_cnt + 32'd1 : '0;
      case (state)
        CPU_FETCH: if (xfer_done) ir <= mem.mem_rdata[31:0];
        CPU_EXECUTE: begin
          result     <= alu_out;
          ea         <= ea_calc;
          store_data <= rt_val;
          next_pc    <= (op == OP_BEQ && rs_val == rt_val) ? branch_target : pc_plus4;
        end
        CPU_MEM: if (xfer_done && !mem.mem_we) result <= mem.mem_rdata;
        CPU_WRITEBACK: begin
          pc      <= next_pc;
          instret <= instret + 32'd1;
        end
        default: ;
      endcase
      if (state == CPU_EXECUTE && state_next == CPU_HALT) begin
        halted  <= 1'b1;
        instret <= instret + 32'd1;
      end
      if (state != CPU_FAULT && state_next == CPU_FAULT) begin
        fault      <= 1'b1;
        fault_code <= fault_next;
      end
    end
  end
endmodule

// File: tb/tb_cpu_mc_core.sv
// Directed self-checking bench for cpu_mc_core: a 32-bit core at RESET_PC=0x100 and a
// 64-bit, 8-register core at RESET_PC=0, both with TIMEOUT=8.
module tb_cpu_mc_core;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, rst64 = 1'b1;
  logic auto_ack = 1'b1, man_ack = 1'b0, auto_ack64 = 1'b1, man_ack64 = 1'b0;

  cpu_mc_core_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
  cpu_mc_core_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus64 ();

  cpu_state_t  state, state64;
  cpu_fault_t  fault_code, fault_code64;
  logic        halted, fault, halted64, fault64;
  logic [31:0] instret, instret64;

  cpu_mc_core #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(32),
                .RESET_PC(32'h100), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .mem(bus), .state(state), .halted(halted),
    .fault(fault), .fault_code(fault_code), .instret(instret));

  cpu_mc_core #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .NUM_REGS(8),
                .RESET_PC(32'h0), .TIMEOUT(8)) dut64 (
    .clk(clk), .rst(rst64), .mem(bus64), .state(state64), .halted(halted64),
    .fault(fault64), .fault_code(fault_code64), .instret(instret64));

  // Zero-wait memories; acks can be withheld or driven by hand per core.
  logic [31:0] mem   [256];
  logic [63:0] mem64 [256];
  assign bus.mem_ack     = bus.mem_req & (auto_ack | man_ack);
  assign bus.mem_rdata   = mem[bus.mem_addr[9:2]];
  assign bus64.mem_ack   = bus64.mem_req & (auto_ack64 | man_ack64);
  assign bus64.mem_rdata = mem64[bus64.mem_addr[9:2]];

  logic [31:0] st_addr [16];
  logic [63:0] st_data [16];
  logic [31:0] st64_addr [16];
  logic [63:0] st64_data [16];
  int st_cnt = 0, st64_cnt = 0, req41_cnt = 0;

  always @(posedge clk) begin
    if (!rst && bus.mem_req && bus.mem_ack && bus.mem_we) begin
      st_addr[st_cnt[3:0]] <= bus.mem_addr;
      st_data[st_cnt[3:0]] <= 64'(bus.mem_wdata);
      st_cnt <= st_cnt + 1;
    end
    if (bus.mem_req && bus.mem_addr == 32'h41) req41_cnt <= req41_cnt + 1;
  end

  always @(posedge clk) begin
    if (!rst64 && bus64.mem_req && bus64.mem_ack && bus64.mem_we) begin
      st64_addr[st64_cnt[3:0]] <= bus64.mem_addr;
      st64_data[st64_cnt[3:0]] <= bus64.mem_wdata;
      st64_cnt <= st64_cnt + 1;
    end
  end

  int checks = 0, passes = 0;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    else passes++;
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] op, input int rs, input int rt, input int rd);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'b0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] word);
    mem[addr[9:2]] = word;
  endtask

  // Two reset edges, check the quiescent outputs while rst is still high, then release.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_output("rst_state",   64'(state), 64'(CPU_RESET));
    check_output("rst_req",     64'(bus.mem_req), 64'd0);
    check_output("rst_we",      64'(bus.mem_we), 64'd0);
    check_output("rst_addr",    64'(bus.mem_addr), 64'd0);
    check_output("rst_wdata",   64'(bus.mem_wdata), 64'd0);
    check_output("rst_halted",  64'(halted), 64'd0);
    check_output("rst_fault",   64'(fault), 64'd0);
    check_output("rst_fcode",   64'(fault_code), 64'(FLT_NONE));
    check_output("rst_instret", 64'(instret), 64'd0);
    rst = 1'b0;
  endtask

  task automatic wait_stop(input string tag, input int budget);
    int n = 0;
    while (!(halted || fault) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, 64'(n < budget), 64'd1);
  endtask

  initial begin
    int n, base, idx;
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 32'h0;
      mem64[i] = 64'h0;
    end

    // Straight-line program ending in a store and HALT.
    put(32'h100, enc_i(OP_ADDI, 0, 1, 16'd5));
    put(32'h104, enc_i(OP_ADDI, 0, 2, 16'hFFFD));
    put(32'h108, enc_r(OP_ADD, 1, 2, 3));
    put(32'h10C, enc_i(OP_SW, 0, 3, 16'h0040));
    put(32'h110, {OP_HALT, 26'b0});
    apply_reset();
    @(negedge clk);
    check_output("first_state", 64'(state), 64'(CPU_FETCH));
    check_output("first_req",   64'(bus.mem_req), 64'd1);
    check_output("first_addr",  64'(bus.mem_addr), 64'h100);
    @(negedge clk); check_output("seq_decode", 64'(state), 64'(CPU_DECODE));
    @(negedge clk); check_output("seq_exec",   64'(state), 64'(CPU_EXECUTE));
    @(negedge clk); check_output("seq_wb",     64'(state), 64'(CPU_WRITEBACK));
    @(negedge clk);
    check_output("seq_fetch2",  64'(bus.mem_addr), 64'h104);
    check_output("seq_instret", 64'(instret), 64'd1);
    base = st_cnt;
    wait_stop("prog_stop", 100);
    idx = (st_cnt - 1) & 15;
    check_output("prog_halted",  64'(halted), 64'd1);
    check_output("prog_fault",   64'(fault), 64'd0);
    check_output("prog_state",   64'(state), 64'(CPU_HALT));
    check_output("prog_instret", 64'(instret), 64'd5);
    check_output("prog_stcnt",   64'(st_cnt - base), 64'd1);
    check_output("prog_staddr",  64'(st_addr[idx]), 64'h40);
    check_output("prog_stdata",  st_data[idx], 64'd2);

    // Wrap-around add, a not-taken branch, then a branch-to-self loop.
    put(32'h100, enc_i(OP_ADDI, 0, 4, 16'hFFFF));
    put(32'h104, enc_i(OP_BEQ, 4, 0, 16'd8));
    put(32'h108, enc_i(OP_ADDI, 0, 5, 16'd1));
    put(32'h10C, enc_r(OP_ADD, 4, 5, 6));
    put(32'h110, enc_i(OP_SW, 0, 6, 16'h0048));
    put(32'h114, enc_i(OP_BEQ, 0, 0, 16'hFFFF));
    apply_reset();
    n = 0;
    while (!(state == CPU_FETCH && bus.mem_addr == 32'h114) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output("loop_reach",   64'(n < 100), 64'd1);
    check_output("loop_instret", 64'(instret), 64'd5);
    idx = (st_cnt - 1) & 15;
    check_output("wrap_staddr",  64'(st_addr[idx]), 64'h48);
    check_output("wrap_stdata",  st_data[idx], 64'd0);
    for (int k = 1; k <= 3; k++) begin
      repeat (4) @(negedge clk);
      check_output("loop_state", 64'(state), 64'(CPU_FETCH));
      check_output("loop_pc",    64'(bus.mem_addr), 64'h114);
      check_output("loop_cnt",   64'(instret), 64'(5 + k));
    end

    // Withheld ack: eight waiting cycles then a timeout fault.
    auto_ack = 1'b0;
    apply_reset();
    n = 0;
    @(negedge clk);
    while (state == CPU_FETCH && n < 20) begin
      n++;
      @(negedge clk);
    end
    check_output("to_waits",   64'(n), 64'd8);
    check_output("to_state",   64'(state), 64'(CPU_FAULT));
    check_output("to_fault",   64'(fault), 64'd1);
    check_output("to_code",    64'(fault_code), 64'(FLT_TIMEOUT));
    check_output("to_req",     64'(bus.mem_req), 64'd0);
    check_output("to_halted",  64'(halted), 64'd0);
    check_output("to_instret", 64'(instret), 64'd0);
    repeat (3) @(negedge clk);
    check_output("to_sticky",  64'(fault), 64'd1);

    // Ack arriving on the expiry cycle completes the fetch.
    apply_reset();
    repeat (8) @(negedge clk);
    check_output("late_fetch", 64'(state), 64'(CPU_FETCH));
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    check_output("late_decode", 64'(state), 64'(CPU_DECODE));
    check_output("late_nofault", 64'(fault), 64'd0);
    auto_ack = 1'b1;

    // Illegal opcode.
    put(32'h100, {6'h3E, 26'b0});
    apply_reset();
    wait_stop("ill_stop", 50);
    check_output("ill_code",    64'(fault_code), 64'(FLT_ILLEGAL));
    check_output("ill_halted",  64'(halted), 64'd0);
    check_output("ill_instret", 64'(instret), 64'd0);

    // r0 stays zero; misaligned load faults without a request and leaves rt intact.
    put(32'h100, enc_i(OP_ADDI, 0, 0, 16'd7));
    put(32'h104, enc_i(OP_SW, 0, 0, 16'h0044));
    put(32'h108, enc_i(OP_ADDI, 0, 7, 16'd9));
    put(32'h10C, enc_i(OP_LW, 0, 7, 16'h0041));
    apply_reset();
    base = req41_cnt;
    wait_stop("mis_stop", 100);
    idx = (st_cnt - 1) & 15;
    check_output("r0_staddr",   64'(st_addr[idx]), 64'h44);
    check_output("r0_stdata",   st_data[idx], 64'd0);
    check_output("mis_code",    64'(fault_code), 64'(FLT_MISALIGN));
    check_output("mis_instret", 64'(instret), 64'd3);
    check_output("mis_noreq",   64'(req41_cnt - base), 64'd0);
    check_output("mis_rt",      64'(dut.u_rf.regs[7]), 64'd9);
    check_output("mis_req",     64'(bus.mem_req), 64'd0);

    // Reset while a load is waiting in MEM, with an ack presented in the reset cycle.
    mem[16] = 32'h1234;
    put(32'h100, enc_i(OP_ADDI, 0, 2, 16'd3));
    put(32'h104, enc_i(OP_LW, 0, 1, 16'h0040));
    apply_reset();
    n = 0;
    while (!(state == CPU_EXECUTE && instret == 32'd1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output("mr_reach", 64'(n < 50), 64'd1);
    auto_ack = 1'b0;
    @(negedge clk);
    check_output("mr_mem",  64'(state), 64'(CPU_MEM));
    check_output("mr_r2",   64'(dut.u_rf.regs[2]), 64'd3);
    rst = 1'b1;
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    check_output("mr_state", 64'(state), 64'(CPU_RESET));
    check_output("mr_req",   64'(bus.mem_req), 64'd0);
    check_output("mr_r1",    64'(dut.u_rf.regs[1]), 64'd0);
    check_output("mr_r2z",   64'(dut.u_rf.regs[2]), 64'd0);
    check_output("mr_instret", 64'(instret), 64'd0);
    rst = 1'b0;
    auto_ack = 1'b1;

    // 64-bit core with 8 registers: index wraps mod 8, full-width arithmetic and stores.
    mem64[0] = 64'(enc_i(OP_ADDI, 0, 9, 16'hFFFF));
    mem64[1] = 64'(enc_i(OP_ADDI, 0, 2, 16'd1));
    mem64[2] = 64'(enc_r(OP_ADD, 1, 2, 3));
    mem64[3] = 64'(enc_i(OP_SW, 0, 1, 16'h0040));
    mem64[4] = 64'(enc_i(OP_SW, 0, 3, 16'h0048));
    mem64[5] = 64'({OP_HALT, 26'b0});
    @(negedge clk);
    check_output("w64_rst_state", 64'(state64), 64'(CPU_RESET));
    rst64 = 1'b0;
    n = 0;
    while (!(halted64 || fault64) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output("w64_stop",    64'(n < 200), 64'd1);
    check_output("w64_halted",  64'(halted64), 64'd1);
    check_output("w64_instret", 64'(instret64), 64'd6);
    check_output("w64_stcnt",   64'(st64_cnt), 64'd2);
    check_output("w64_st0addr", 64'(st64_addr[0]), 64'h40);
    check_output("w64_st0data", st64_data[0], 64'hFFFF_FFFF_FFFF_FFFF);
    check_output("w64_st1data", st64_data[1], 64'd0);
    check_output("w64_r1",      dut64.u_rf.regs[1], 64'hFFFF_FFFF_FFFF_FFFF);

    // Reset mid-store on the 64-bit core.
    @(negedge clk);
    rst64 = 1'b1;
    repeat (2) @(negedge clk);
    rst64 = 1'b0;
    n = 0;
    while (!(state64 == CPU_EXECUTE && instret64 == 32'd3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output("w64_mr_reach", 64'(n < 100), 64'd1);
    auto_ack64 = 1'b0;
    @(negedge clk);
    check_output("w64_mr_mem", 64'(state64), 64'(CPU_MEM));
    check_output("w64_mr_we",  64'(bus64.mem_we), 64'd1);
    rst64 = 1'b1;
    man_ack64 = 1'b1;
    @(negedge clk);
    man_ack64 = 1'b0;
    check_output("w64_mr_state", 64'(state64), 64'(CPU_RESET));
    check_output("w64_mr_req",   64'(bus64.mem_req), 64'd0);
    check_output("w64_mr_r1",    dut64.u_rf.regs[1], 64'd0);
    check_output("w64_mr_instret", 64'(instret64), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
